// File: rtl/rf_wb_checker_pkg.sv
// Shared types for the register-file writeback checker: error causes, checker
// states and a constant-safe clog2.
package rf_chk_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_MISMATCH   = 2'd1,
    CAUSE_UNEXPECTED = 2'd2,
    CAUSE_TIMEOUT    = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rf_wb_checker_if.sv
// Expected-write push channel and processor writeback tap seen by the checker.
interface rf_wb_checker_if #(
  parameter int RSEL_W = 3,
  parameter int DATA_W = 16
);
  logic              exp_valid;
  logic              exp_ready;
  logic [RSEL_W-1:0] exp_reg;
  logic [DATA_W-1:0] exp_data;
  logic              wb_en;
  logic [RSEL_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output exp_valid, exp_reg, exp_data, wb_en, wb_reg, wb_data,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_reg, exp_data, wb_en, wb_reg, wb_data,
    output exp_ready
  );
endinterface

// File: rtl/rf_wb_checker_sync_fifo.sv
// Single-clock FIFO with combinational head, synchronous flush and occupancy count.
// A push while full is refused even if a pop happens in the same cycle.
module sync_fifo
  import rf_chk_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == DEPTH_CNT);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/rf_wb_checker.sv
// Writeback scoreboard: compares each register-file write against the head of an
// ordered expected-write queue, with stall watchdog and first-error capture.
module rf_wb_checker
  import rf_chk_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NREGS       = 8,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 1,
  localparam int RSEL_W = clog2(NREGS),
  localparam int PEND_W = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  rf_wb_checker_if.slave    bus,
  output logic              mismatch,
  output logic              err,
  output logic [1:0]        cause,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [PEND_W-1:0] pending
);

  localparam int              WD_W    = clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e             state_r, state_nxt_s;
  cause_e             cause_r, cause_nxt_s;
  logic [WD_W-1:0]    wdog_r, wdog_nxt_s;
  logic [CNT_W-1:0]   pass_cnt_r, pass_cnt_nxt_s;
  logic [CNT_W-1:0]   fail_cnt_r, fail_cnt_nxt_s;
  logic               err_r, err_nxt_s;
  logic               mismatch_r;

  logic [RSEL_W+DATA_W-1:0] head_s;
  logic [RSEL_W-1:0]        head_reg_s;
  logic [DATA_W-1:0]        head_data_s;
  logic                     full_s, empty_s;
  logic [PEND_W-1:0]        count_s, pend_nxt_s;

  logic halted_s, push_s, wb_evt_s, hit_s, pop_s;
  logic pass_s, mism_s, unexp_s, tmo_s, error_s;

  sync_fifo #(
    .WIDTH (RSEL_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clr),
    .push  (push_s && !clr),
    .pop   (pop_s && !clr),
    .din   ({bus.exp_reg, bus.exp_data}),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  assign {head_reg_s, head_data_s} = head_s;

  assign halted_s      = (state_r == ST_HALTED);
  assign bus.exp_ready = !full_s && !halted_s;
  assign push_s        = bus.exp_valid && bus.exp_ready;
  assign wb_evt_s      = bus.wb_en && !halted_s;
  assign hit_s         = (head_reg_s == bus.wb_reg) && (head_data_s == bus.wb_data);
  assign pop_s         = wb_evt_s && !empty_s;
  assign pass_s        = pop_s && hit_s;
  assign mism_s        = pop_s && !hit_s;
  assign unexp_s       = wb_evt_s && empty_s;
  assign tmo_s         = (state_r == ST_ARMED) && !bus.wb_en && (wdog_r == WD_LAST);
  assign error_s       = mism_s || unexp_s || tmo_s;
  assign pend_nxt_s    = count_s + {{(PEND_W-1){1'b0}}, push_s} - {{(PEND_W-1){1'b0}}, pop_s};

  // Checker state: IDLE/ARMED follow post-update occupancy; HALTED only via error.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_ARMED: begin
        if (error_s && (STOP_ON_ERR != 0)) state_nxt_s = ST_HALTED;
        else if (pend_nxt_s != '0)         state_nxt_s = ST_ARMED;
        else                               state_nxt_s = ST_IDLE;
      end
      ST_HALTED: state_nxt_s = ST_HALTED;
      default:   state_nxt_s = ST_IDLE;
    endcase
    if (clr) state_nxt_s = ST_IDLE;
    else     state_nxt_s = state_nxt_s;
  end

  // Watchdog, saturating counters and first-error capture.
  always_comb begin
    wdog_nxt_s     = '0;
    pass_cnt_nxt_s = pass_cnt_r;
    fail_cnt_nxt_s = fail_cnt_r;
    err_nxt_s      = err_r;
    cause_nxt_s    = cause_r;
    if (clr) begin
      wdog_nxt_s     = '0;
      pass_cnt_nxt_s = '0;
      fail_cnt_nxt_s = '0;
      err_nxt_s      = 1'b0;
      cause_nxt_s    = CAUSE_NONE;
    end else begin
      if ((state_r == ST_ARMED) && !bus.wb_en && !tmo_s) wdog_nxt_s = wdog_r + 1'b1;
      else                                               wdog_nxt_s = '0;
      if (pass_s && (pass_cnt_r != '1))  pass_cnt_nxt_s = pass_cnt_r + 1'b1;
      else                               pass_cnt_nxt_s = pass_cnt_r;
      if (error_s && (fail_cnt_r != '1)) fail_cnt_nxt_s = fail_cnt_r + 1'b1;
      else                               fail_cnt_nxt_s = fail_cnt_r;
      err_nxt_s = err_r || error_s;
      if (error_s && (cause_r == CAUSE_NONE)) begin
        if (mism_s)       cause_nxt_s = CAUSE_MISMATCH;
        else if (unexp_s) cause_nxt_s = CAUSE_UNEXPECTED;
        else              cause_nxt_s = CAUSE_TIMEOUT;
      end else begin
        cause_nxt_s = cause_r;
      end
    end
  end

  // Registered checker state and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cause_r    <= CAUSE_NONE;
      wdog_r     <= '0;
      pass_cnt_r <= '0;
      fail_cnt_r <= '0;
      err_r      <= 1'b0;
      mismatch_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cause_r    <= cause_nxt_s;
      wdog_r     <= wdog_nxt_s;
      pass_cnt_r <= pass_cnt_nxt_s;
      fail_cnt_r <= fail_cnt_nxt_s;
      err_r      <= err_nxt_s;
      mismatch_r <= error_s && !clr;
    end
  end

  assign mismatch = mismatch_r;
  assign err      = err_r;
  assign cause    = cause_r;
  assign pass_cnt = pass_cnt_r;
  assign fail_cnt = fail_cnt_r;
  assign pending  = count_s;

endmodule

// File: tb/tb_rf_wb_checker.sv
// Directed bench: a halting checker is scoreboarded against a queue model; a
// non-halting twin on identical stimulus covers the repeated watchdog.
module tb_rf_wb_checker;
  import rf_chk_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic        exp_valid, wb_en;
  logic [2:0]  exp_reg, wb_reg;
  logic [15:0] exp_data, wb_data;

  logic        mis0, err0, mis1, err1;
  logic [1:0]  cause0, cause1;
  logic [15:0] pc0, fc0, pc1, fc1;
  logic [3:0]  pend0, pend1;

  int total = 0;
  int bad   = 0;

  rf_wb_checker_if #(.RSEL_W(3), .DATA_W(16)) bus0 ();
  rf_wb_checker_if #(.RSEL_W(3), .DATA_W(16)) bus1 ();

  assign bus0.exp_valid = exp_valid;
  assign bus0.exp_reg   = exp_reg;
  assign bus0.exp_data  = exp_data;
  assign bus0.wb_en     = wb_en;
  assign bus0.wb_reg    = wb_reg;
  assign bus0.wb_data   = wb_data;
  assign bus1.exp_valid = exp_valid;
  assign bus1.exp_reg   = exp_reg;
  assign bus1.exp_data  = exp_data;
  assign bus1.wb_en     = wb_en;
  assign bus1.wb_reg    = wb_reg;
  assign bus1.wb_data   = wb_data;

  rf_wb_checker #(.DATA_W(16), .NREGS(8), .DEPTH(8), .TIMEOUT(64), .CNT_W(16), .STOP_ON_ERR(1)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus0), .mismatch(mis0), .err(err0),
    .cause(cause0), .pass_cnt(pc0), .fail_cnt(fc0), .pending(pend0));

  rf_wb_checker #(.DATA_W(16), .NREGS(8), .DEPTH(8), .TIMEOUT(64), .CNT_W(16), .STOP_ON_ERR(0)) u_dut_nh (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus1), .mismatch(mis1), .err(err1),
    .cause(cause1), .pass_cnt(pc1), .fail_cnt(fc1), .pending(pend1));

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] r; logic [15:0] d; } ent_t;
  typedef struct { logic mis; int pc; int fc; logic err; logic [1:0] cause; int pend; logic rdy; } res_t;

  ent_t       mq[$];
  res_t       sbq[$];
  int         m_pass, m_fail;
  logic       m_err, m_halt;
  logic [1:0] m_cause;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pass = 0; m_fail = 0; m_err = 1'b0; m_halt = 1'b0; m_cause = 2'd0;
  endtask

  // One clock of stimulus on the halting checker; model predicts, DUT checked after the edge.
  task automatic step(input logic ev, input logic [2:0] er, input logic [15:0] ed,
                      input logic we, input logic [2:0] wr, input logic [15:0] wd, input logic c);
    res_t r; ent_t h; ent_t e; logic fail_e; logic ready; logic [1:0] code;
    exp_valid = ev; exp_reg = er; exp_data = ed;
    wb_en = we; wb_reg = wr; wb_data = wd; clr = c;
    fail_e = 1'b0; code = 2'd0;
    ready = (mq.size() != 8) && !m_halt;
    if (c) begin
      model_reset();
    end else begin
      if (we && !m_halt) begin
        if (mq.size() == 0) begin
          fail_e = 1'b1; code = 2'd2;
        end else begin
          h = mq.pop_front();
          if (h.r == wr && h.d == wd) m_pass++;
          else begin fail_e = 1'b1; code = 2'd1; end
        end
      end
      if (ev && ready) begin e.r = er; e.d = ed; mq.push_back(e); end
      if (fail_e) begin
        m_fail++; m_err = 1'b1; m_halt = 1'b1;
        if (m_cause == 2'd0) m_cause = code;
      end
    end
    r.mis = fail_e; r.pc = m_pass; r.fc = m_fail; r.err = m_err; r.cause = m_cause;
    r.pend = mq.size(); r.rdy = (mq.size() != 8) && !m_halt;
    sbq.push_back(r);
    @(posedge clk); #1;
    exp_valid = 1'b0; wb_en = 1'b0; clr = 1'b0;
    r = sbq.pop_front();
    chk("mismatch", 32'(mis0), 32'(r.mis));
    chk("pass_cnt", 32'(pc0), r.pc);
    chk("fail_cnt", 32'(fc0), r.fc);
    chk("err", 32'(err0), 32'(r.err));
    chk("cause", 32'(cause0), 32'(r.cause));
    chk("pending", 32'(pend0), r.pend);
    chk("exp_ready", 32'(bus0.exp_ready), 32'(r.rdy));
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; exp_valid = 1'b0; wb_en = 1'b0;
    exp_reg = 3'd0; exp_data = 16'h0; wb_reg = 3'd0; wb_data = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pass", 32'(pc0), 32'd0);
    chk("rst_fail", 32'(fc0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_pend", 32'(pend0), 32'd0);
    chk("rst_mis", 32'(mis0), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(bus0.exp_ready), 32'd1);

    // In-order matches
    step(1'b1, 3'd0, 16'h0010, 1'b0, 3'd0, 16'h0, 1'b0);
    step(1'b1, 3'd1, 16'h0001, 1'b0, 3'd0, 16'h0, 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'h0010, 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 16'h0001, 1'b0);
    chk("t1_pass", 32'(pc0), 32'd2);
    chk("t1_state", 32'(u_dut.state_r), 32'(ST_IDLE));
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);

    // Data mismatch then halted
    step(1'b1, 3'd2, 16'h1234, 1'b0, 3'd0, 16'h0, 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h1235, 1'b0);
    chk("t2_cause", 32'(cause0), 32'd1);
    chk("t2_ready", 32'(bus0.exp_ready), 32'd0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h1234, 1'b0);
    step(1'b1, 3'd5, 16'h0055, 1'b1, 3'd6, 16'h0066, 1'b0);
    chk("t2_frozen", 32'(fc0), 32'd1);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);

    // Unexpected write with simultaneous push
    step(1'b1, 3'd3, 16'h0005, 1'b1, 3'd3, 16'h0005, 1'b0);
    chk("t3_cause", 32'(cause0), 32'd2);
    chk("t3_pend", 32'(pend0), 32'd1);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);

    // Full queue: 9th push refused despite concurrent pop
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 16'h0100 + 16'(i), 1'b0, 3'd0, 16'h0, 1'b0);
    chk("t4_full_ready", 32'(bus0.exp_ready), 32'd0);
    step(1'b1, 3'd7, 16'hBEEF, 1'b1, 3'd0, 16'h0100, 1'b0);
    chk("t4_pend", 32'(pend0), 32'd7);
    chk("t4_ready", 32'(bus0.exp_ready), 32'd1);
    for (int i = 1; i < 8; i++) step(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 16'h0100 + 16'(i), 1'b0);
    chk("t4_pass", 32'(pc0), 32'd8);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);

    // Watchdog
    step(1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 16'h0, 1'b0);
    repeat (63) @(posedge clk);
    #1;
    chk("t5_pre_cause", 32'(cause1), 32'd0);
    @(posedge clk); #1;
    chk("t5_cause", 32'(cause1), 32'd3);
    chk("t5_err", 32'(err1), 32'd1);
    chk("t5_mis", 32'(mis1), 32'd1);
    chk("t5_fail", 32'(fc1), 32'd1);
    chk("t5_pend", 32'(pend1), 32'd1);
    chk("t5_halt_cause", 32'(cause0), 32'd3);
    @(posedge clk); #1;
    chk("t5_mis_pulse", 32'(mis1), 32'd0);
    repeat (62) @(posedge clk);
    #1;
    chk("t5_pre_fail2", 32'(fc1), 32'd1);
    @(posedge clk); #1;
    chk("t5_fail2", 32'(fc1), 32'd2);
    chk("t5_cause2", 32'(cause1), 32'd3);
    chk("t5_pend2", 32'(pend1), 32'd1);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 16'h0020 + 16'(i), 1'b0, 3'd0, 16'h0, 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'hDEAD, 1'b0);
    chk("t6_pre_pend", 32'(pend0), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("t6_pend", 32'(pend0), 32'd0);
    chk("t6_err", 32'(err0), 32'd0);
    chk("t6_cause", 32'(cause0), 32'd0);
    chk("t6_fail", 32'(fc0), 32'd0);
    chk("t6_mis", 32'(mis0), 32'd0);
    chk("t6_nh_pend", 32'(pend1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_ready", 32'(bus0.exp_ready), 32'd1);

    // Synchronous clear with concurrent push
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 16'h0030 + 16'(i), 1'b0, 3'd0, 16'h0, 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'hDEAD, 1'b0);
    chk("t6c_pre_err", 32'(err0), 32'd1);
    step(1'b1, 3'd6, 16'h0066, 1'b0, 3'd0, 16'h0, 1'b1);
    chk("t6c_pend", 32'(pend0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_checker.md
Name: rf_wb_checker

Overview:
Synthesizable self-checking monitor that sits beside proc and compares every register-file writeback (select, data) against an ordered queue of expected writes loaded by the bench or a trace loader. It generalises the per-instruction register checks into a parametrised scoreboard with:
- configurable data width, register count and queue depth;
- a stall watchdog;
- first-error capture and optional halt-on-error mode.

Parameters:
DATA_W, 16, writeback data width
NREGS, 8, number of architectural registers; RSEL_W = clog2(NREGS)
DEPTH, 8, expected-write queue entries (power of 2, >=2)
TIMEOUT, 64, max consecutive cycles with queue non-empty and no writeback
CNT_W, 16, width of pass/fail counters
STOP_ON_ERR, 1, 1 = enter HALTED on first error; 0 = keep checking

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous clear: flush queue, zero counters, clear err/cause, go IDLE
exp_valid  in  1  expected-write entry offered
exp_ready  out  1  queue can accept (not full and not HALTED)
exp_reg  in  RSEL_W  expected destination register
exp_data  in  DATA_W  expected write data
wb_en  in  1  proc register-file write enable this cycle
wb_reg  in  RSEL_W  proc write select (rf_ws)
wb_data  in  DATA_W  proc write data (rf_wd)
mismatch  out  1  one-cycle pulse, cycle after a failing event
err  out  1  sticky error flag
cause  out  2  first-error code: 0 NONE, 1 MISMATCH, 2 UNEXPECTED, 3 TIMEOUT
pass_cnt  out  CNT_W  matched writebacks
fail_cnt  out  CNT_W  failed events (mismatch, unexpected, timeout)
pending  out  clog2(DEPTH)+1  entries currently queued

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; queue is emptied.
  - All outputs are 0, except exp_ready=1 once rst deasserts.
- States:
  - IDLE: queue empty.
  - ARMED: queue non-empty.
  - HALTED: entered only when STOP_ON_ERR=1 and an error occurs.
  - IDLE and ARMED move between each other based on the post-update pending count.
- Push: exp_valid & exp_ready writes {exp_reg, exp_data} at the tail.
  - exp_ready = (pending != DEPTH) && state != HALTED. It is registered-state derived and does not depend on a same-cycle pop.
  - When full, push is refused even if a pop occurs that cycle.
- Writeback event (wb_en=1, state != HALTED), compared against the head entry only:
  - Queue empty: UNEXPECTED. A push in the same cycle is not bypassed; the writeback is still UNEXPECTED and the pushed entry remains queued.
  - Head matches (reg and data both equal): pass_cnt++, pop.
  - Head does not match: MISMATCH, fail_cnt++, pop (resynchronises to the next entry).
- Watchdog:
  - wdog counts cycles with state==ARMED and wb_en=0.
  - It clears on any wb_en, when the queue is empty, or on clr.
  - When wdog reaches TIMEOUT-1: TIMEOUT error, fail_cnt++, wdog clears. The queue is not popped.
- Error handling:
  - On any error: mismatch pulses high for exactly the next cycle and err sets.
  - cause latches only if currently NONE, so the first error wins.
  - If STOP_ON_ERR=1, next state is HALTED. In HALTED, wb_en and the watchdog are ignored, pass_cnt/fail_cnt freeze, and only clr or rst exits.
- Counters saturate at all-ones; no wrap.
- Latency: counters, pending, err, cause and mismatch are all registered and update one cycle after the event.
- pending may increment and decrement in the same cycle (net 0).
- clr has priority over push, writeback and watchdog in the same cycle.
- rst asserted mid-operation aborts immediately; no partial state survives.

Decomposition:
- Package rf_chk_pkg holds:
  - cause codes CAUSE_NONE/MISMATCH/UNEXPECTED/TIMEOUT;
  - state encoding ST_IDLE/ST_ARMED/ST_HALTED;
  - clog2 function.
- One sub-module, sync_fifo (WIDTH=RSEL_W+DATA_W, DEPTH). It provides:
  - push/pop/full/empty/count and head data visible combinationally;
  - the same clk/rst (async active-low) and a synchronous flush.
- Checker FSM, watchdog and counters live in rf_wb_checker.

Test Plan:
1. In-order match: push (r0,0x0010),(r1,0x0001); wb r0=0x0010 then r1=0x0001 -> pass_cnt=2, fail_cnt=0, err=0, pending=0, state IDLE.
2. Data mismatch: push (r2,0x1234); wb r2=0x1235 -> mismatch pulse 1 cycle later, err=1, cause=1, fail_cnt=1; with STOP_ON_ERR=1, exp_ready=0 and a later wb changes nothing until clr.
3. Unexpected write with simultaneous push: empty queue; same cycle wb r3=0x0005 and push (r3,0x0005) -> cause=2, fail_cnt=1, pending=1.
4. Full queue (DEPTH=8): push 8 entries -> exp_ready=0; 9th offered with a simultaneous matching wb -> 9th refused, pending=7, next cycle exp_ready=1.
5. Watchdog (TIMEOUT=64): push 1 entry, hold wb_en=0 -> cause=3 and err=1 after 64 cycles in ARMED, pending stays 1; STOP_ON_ERR=0 -> second timeout 64 cycles later, fail_cnt=2.
6. Reset/clear: pull rst low mid-stream with pending=3 and err=1 -> all outputs 0 immediately; repeat with clr=1 -> same result one cycle later, with a concurrent push ignored.
